// File: rtl/obstacle_pkg.sv
// Shared types and defaults for the obstacle spawn controller.
// Includes the FSM state encoding and the index-width helper used for lane and slot fields.
package obstacle_pkg;

   localparam int DEF_N       = 7;
   localparam int DEF_LANES   = 4;
   localparam int DEF_SLOTS   = 4;
   localparam int DEF_MIN_GAP = 20;
   localparam int DEF_GW      = 5;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      PICK,
      ALLOC,
      OFFER
   } state_t;

   // Index width for a field selecting one of n items; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/obstacle_slot_alloc.sv
// Lowest-index free-slot finder: a purely combinational priority encoder.
// avail has a 1 for each slot that may be taken this cycle.
module obstacle_slot_alloc #(
   parameter int SLOTS = 4,
   parameter int SW    = 2
)(
   input  logic [SLOTS-1:0] avail,
   output logic             found,
   output logic [SW-1:0]    index
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (avail[i]) begin
            found = 1'b1;
            index = SW'(i);
         end
      end
   end

endmodule

// File: rtl/obstacle_spawn_ctrl.sv
// Obstacle spawn scheduler: waits a random tick gap, picks a lane from the LFSR value,
// grabs the lowest free slot and offers the spawn to the renderer over valid/ready.
module obstacle_spawn_ctrl
   import obstacle_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int LANES   = DEF_LANES,
   parameter int SLOTS   = DEF_SLOTS,
   parameter int MIN_GAP = DEF_MIN_GAP,
   parameter int GW      = DEF_GW
)(
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      enable,
   input  logic                      tick,
   input  logic [N-1:0]              rnd,
   input  logic [SLOTS-1:0]          slot_free,
   output logic                      spawn_valid,
   input  logic                      spawn_ready,
   output logic [idx_w(LANES)-1:0]   spawn_lane,
   output logic [idx_w(SLOTS)-1:0]   spawn_slot,
   output logic [SLOTS-1:0]          slot_busy,
   output logic                      stalled,
   output logic [15:0]               spawn_count
);

   localparam int LW = idx_w(LANES);
   localparam int SW = idx_w(SLOTS);
   localparam int CW = $clog2(MIN_GAP + (2 ** GW));

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     countdown;
   logic [CW-1:0]     next_gap;
   logic [LW-1:0]     lane;
   logic [LW-1:0]     last_lane;
   logic [SW-1:0]     slot;
   logic [SLOTS-1:0]  occupied;
   logic [SLOTS-1:0]  accept_onehot;
   logic              accept;
   logic              found;
   logic [SW-1:0]     free_index;

   // A repeat of the previous lane is bumped to the next one so consecutive spawns differ.
   function automatic logic [LW-1:0] pick_lane(input logic [LW-1:0] raw,
                                                input logic [LW-1:0] last);
      return (raw == last) ? raw + LW'(1) : raw;
   endfunction

   function automatic logic [CW-1:0] gap_of(input logic [N-1:0] r);
      return CW'(MIN_GAP) + CW'(r[N-1 -: GW]);
   endfunction

   assign spawn_valid   = (state == OFFER);
   assign spawn_lane    = lane;
   assign spawn_slot    = slot;
   assign accept        = spawn_valid && spawn_ready;
   assign occupied      = slot_busy & ~slot_free;
   assign accept_onehot = accept ? (SLOTS'(1) << slot) : '0;

   obstacle_slot_alloc #(
      .SLOTS (SLOTS),
      .SW    (SW)
   ) u_slot_alloc (
      .avail (~occupied),
      .found (found),
      .index (free_index)
   );

   always_comb begin
      state_next = state;
      stalled    = 1'b0;
      unique case (state)
         IDLE:    if (enable) state_next = WAIT;
         WAIT:    if (tick && countdown == CW'(1)) state_next = PICK;
         PICK:    state_next = ALLOC;
         ALLOC: begin
            if (found) state_next = OFFER;
            else       stalled    = 1'b1;
         end
         OFFER:   if (spawn_ready) state_next = WAIT;
         default: state_next = IDLE;
      endcase
      if (!enable) state_next = IDLE;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Countdown only runs in WAIT; the new gap starts counting from the accepted handshake.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         countdown <= CW'(MIN_GAP);
      end else if (!enable) begin
         countdown <= CW'(MIN_GAP);
      end else if (accept) begin
         countdown <= next_gap;
      end else if (state == WAIT && tick) begin
         countdown <= countdown - CW'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lane     <= '0;
         next_gap <= '0;
         slot     <= '0;
      end else begin
         if (state == PICK) begin
            lane     <= pick_lane(rnd[LW-1:0], last_lane);
            next_gap <= gap_of(rnd);
         end
         if (state == ALLOC && found) begin
            slot <= free_index;
         end
      end
   end

   // Releases land every cycle regardless of state; an accepted slot wins over its own release.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         slot_busy   <= '0;
         last_lane   <= '0;
         spawn_count <= '0;
      end else begin
         slot_busy <= occupied | accept_onehot;
         if (accept) begin
            last_lane   <= lane;
            spawn_count <= spawn_count + 16'd1;
         end
      end
   end

endmodule
